// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b - bi subtractor, LSB first, start/busy/done handshake
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] res;
    logic             brw;
    logic [CW-1:0]    cnt;

    logic             accept;
    logic             last;
    logic             x;
    logic             y;
    logic             d;
    logic             brw_next;
    logic [WIDTH:0]   res_ext;
    logic [WIDTH-1:0] res_next;

    // A new operation is taken in IDLE or DONE; start during RUN is dropped.
    assign accept = start && (state != S_RUN);
    assign last   = (state == S_RUN) && (cnt == CW'(WIDTH - 1));

    // One full-subtractor bit slice; the result enters from the MSB so that
    // after WIDTH shifts the LSB has arrived at bit 0.
    always_comb begin
        x        = sh_a[0];
        y        = sh_b[0];
        d        = x ^ y ^ brw;
        brw_next = (~x & y) | (~(x ^ y) & brw);
        res_ext  = {d, res};
        res_next = res_ext[WIDTH:1];
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE -> RUN on start, RUN -> DONE after WIDTH bits,
    // DONE -> RUN directly when start is already waiting.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  state_next = start ? S_RUN : S_IDLE;
            S_RUN:   state_next = last ? S_DONE : S_RUN;
            S_DONE:  state_next = start ? S_RUN : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath: load on accept, shift one bit per RUN cycle, publish on the last bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_a   <= '0;
            sh_b   <= '0;
            res    <= '0;
            brw    <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            borrow <= 1'b0;
        end else if (accept) begin
            sh_a <= a;
            sh_b <= b;
            brw  <= bi;
            cnt  <= '0;
        end else if (state == S_RUN) begin
            sh_a <= sh_a >> 1;
            sh_b <= sh_b >> 1;
            res  <= res_next;
            brw  <= brw_next;
            cnt  <= cnt + CW'(1);
            if (last) begin
                diff   <= res_next;
                borrow <= brw_next;
            end
        end
    end

    // Status outputs decode straight from the state flops.
    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

endmodule
